// File: rtl/alien_swarm_ctrl.sv
// Alien formation controller: marches the 3x2 swarm across the playfield, clears aliens hit by
// the projectile, and ends the game when the swarm reaches the win line.
module alien_swarm_ctrl #(
   parameter int unsigned LEFT_BOUND        = 144,
   parameter int unsigned RIGHT_BOUND       = 584,
   parameter int unsigned TOP_BOUND         = 134,
   parameter int unsigned GRID_WIDTH        = 40,
   parameter int unsigned ALIENS_WIN_LINE   = 444,
   parameter int unsigned PROJECTILE_WIDTH  = 14,
   parameter int unsigned PROJECTILE_HEIGHT = 14,
   parameter int unsigned MOVE_PERIOD       = 30
) (
   input  logic       clk_25MHz,
   input  logic       d_reset,
   input  logic       frame_tick,
   input  logic [9:0] projectile_x,
   input  logic [9:0] projectile_y,
   input  logic       projectile_active,
   output logic [9:0] aliens_x,
   output logic [9:0] aliens_y,
   output logic [5:0] index_aliens,
   output logic       hit,
   output logic       game_over,
   output logic       all_clear
);

   localparam int unsigned CntW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(MOVE_PERIOD - 1);

   localparam logic [9:0]  GStep  = 10'(GRID_WIDTH);
   localparam logic [10:0] G      = 11'(GRID_WIDTH);
   localparam logic [10:0] G3     = 11'(3 * GRID_WIDTH);
   localparam logic [10:0] G6     = 11'(6 * GRID_WIDTH);
   localparam logic [10:0] RightB = 11'(RIGHT_BOUND);
   localparam logic [10:0] LeftG  = 11'(LEFT_BOUND + GRID_WIDTH);
   localparam logic [10:0] WinY   = 11'(ALIENS_WIN_LINE);
   localparam logic [10:0] Pw     = 11'(PROJECTILE_WIDTH);
   localparam logic [10:0] Ph     = 11'(PROJECTILE_HEIGHT);

   typedef enum logic [1:0] {StMarchR, StMarchL, StOver, StClear} state_e;

   state_e          state;
   logic [CntW-1:0] frame_cnt;
   logic [10:0]     ax11, ay11, px11, py11, bottom;
   logic [10:0]     alien_x [6];
   logic [10:0]     alien_y [6];
   logic [5:0]      overlap, hit_sel;
   logic            step;

   assign ax11      = {1'b0, aliens_x};
   assign ay11      = {1'b0, aliens_y};
   assign px11      = {1'b0, projectile_x};
   assign py11      = {1'b0, projectile_y};
   assign step      = frame_tick && (frame_cnt == CntLast);
   assign all_clear = (index_aliens == 6'd0);

   // Aliens sit on a 2G pitch: bits 0-2 form the top row, bits 3-5 the row below.
   always_comb begin
      overlap = '0;
      for (int i = 0; i < 6; i++) begin
         alien_x[i] = ax11 + 11'((i % 3) * 2 * GRID_WIDTH);
         alien_y[i] = ay11 + 11'((i / 3) * 2 * GRID_WIDTH);
         overlap[i] = index_aliens[i] && projectile_active
                      && (px11 < alien_x[i] + G) && (px11 + Pw > alien_x[i])
                      && (py11 < alien_y[i] + G) && (py11 + Ph > alien_y[i]);
      end
      hit_sel = overlap & (~overlap + 6'd1);
   end

   always_comb begin
      if (|index_aliens[5:3])      bottom = ay11 + G3;
      else if (|index_aliens[2:0]) bottom = ay11 + G;
      else                         bottom = '0;
   end

   always_ff @(posedge clk_25MHz) begin
      if (d_reset) begin
         aliens_x     <= 10'(LEFT_BOUND);
         aliens_y     <= 10'(TOP_BOUND);
         index_aliens <= 6'b111111;
         hit          <= 1'b0;
         game_over    <= 1'b0;
         frame_cnt    <= '0;
         state        <= StMarchR;
      end else begin
         hit <= 1'b0;
         case (state)
            StMarchR, StMarchL: begin
               // Clear and win-line exits freeze the swarm on the transition edge.
               if (index_aliens == 6'd0) begin
                  state <= StClear;
               end else if (bottom > WinY) begin
                  state     <= StOver;
                  game_over <= 1'b1;
               end else begin
                  if (|hit_sel) begin
                     index_aliens <= index_aliens & ~hit_sel;
                     hit          <= 1'b1;
                  end
                  if (step) begin
                     frame_cnt <= '0;
                     if (state == StMarchR) begin
                        if (ax11 + G6 < RightB) begin
                           aliens_x <= aliens_x + GStep;
                        end else begin
                           aliens_y <= aliens_y + GStep;
                           state    <= StMarchL;
                        end
                     end else begin
                        if (ax11 >= LeftG) begin
                           aliens_x <= aliens_x - GStep;
                        end else begin
                           aliens_y <= aliens_y + GStep;
                           state    <= StMarchR;
                        end
                     end
                  end else if (frame_tick) begin
                     frame_cnt <= frame_cnt + CntW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alien_swarm_ctrl.sv
// Bench for alien_swarm_ctrl: directed game scenarios plus randomized play, all checked every
// cycle against a rule-level model of the swarm.
module tb_alien_swarm_ctrl;

   localparam int MP    = 2;
   localparam int G     = 40;
   localparam int LEFT  = 144;
   localparam int RIGHT = 584;
   localparam int TOP   = 134;
   localparam int WIN   = 444;
   localparam int PW    = 14;
   localparam int PH    = 14;

   logic       clk_25MHz = 1'b0;
   logic       d_reset, frame_tick, projectile_active;
   logic [9:0] projectile_x, projectile_y;
   logic [9:0] aliens_x, aliens_y;
   logic [5:0] index_aliens;
   logic       hit, game_over, all_clear;

   always #5 clk_25MHz = ~clk_25MHz;

   alien_swarm_ctrl #(
      .LEFT_BOUND       (LEFT),
      .RIGHT_BOUND      (RIGHT),
      .TOP_BOUND        (TOP),
      .GRID_WIDTH       (G),
      .ALIENS_WIN_LINE  (WIN),
      .PROJECTILE_WIDTH (PW),
      .PROJECTILE_HEIGHT(PH),
      .MOVE_PERIOD      (MP)
   ) dut (
      .clk_25MHz        (clk_25MHz),
      .d_reset          (d_reset),
      .frame_tick       (frame_tick),
      .projectile_x     (projectile_x),
      .projectile_y     (projectile_y),
      .projectile_active(projectile_active),
      .aliens_x         (aliens_x),
      .aliens_y         (aliens_y),
      .index_aliens     (index_aliens),
      .hit              (hit),
      .game_over        (game_over),
      .all_clear        (all_clear)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       s_valid = 1'b0;
   bit       s_rst, s_tick, s_act;
   int       s_px, s_py;
   int       m_x, m_y, m_ticks;
   bit [5:0] m_mask;
   bit       m_right, m_over, m_clear, m_go, m_hit;

   always @(posedge clk_25MHz) begin
      if (d_reset) s_valid <= 1'b1;
      s_rst  <= d_reset;
      s_tick <= frame_tick;
      s_act  <= projectile_active;
      s_px   <= int'(projectile_x);
      s_py   <= int'(projectile_y);
   end

   function automatic bit touches(input int i, input int px, input int py);
      int ax, ay;
      ax = m_x + 2 * G * (i % 3);
      ay = m_y + 2 * G * (i / 3);
      return (px < ax + G) && (px + PW > ax) && (py < ay + G) && (py + PH > ay);
   endfunction

   function automatic int lowest_edge();
      int b = 0;
      for (int i = 0; i < 6; i++)
         if (m_mask[i] && (m_y + 2 * G * (i / 3) + G > b)) b = m_y + 2 * G * (i / 3) + G;
      return b;
   endfunction

   task automatic model_step();
      if (s_rst) begin
         m_x = LEFT; m_y = TOP; m_mask = 6'b111111; m_ticks = 0;
         m_right = 1; m_over = 0; m_clear = 0; m_go = 0; m_hit = 0;
      end else begin
         m_hit = 0;
         if (!m_over && !m_clear) begin
            if (m_mask == 0) begin
               m_clear = 1;
            end else if (lowest_edge() > WIN) begin
               m_over = 1;
               m_go   = 1;
            end else begin
               if (s_act) begin
                  for (int i = 0; i < 6; i++) begin
                     if (m_mask[i] && touches(i, s_px, s_py)) begin
                        m_mask[i] = 0;
                        m_hit     = 1;
                        break;
                     end
                  end
               end
               if (s_tick) begin
                  m_ticks++;
                  if (m_ticks == MP) begin
                     m_ticks = 0;
                     if (m_right) begin
                        if (m_x + 6 * G < RIGHT) m_x += G;
                        else begin m_y += G; m_right = 0; end
                     end else begin
                        if (m_x >= LEFT + G) m_x -= G;
                        else begin m_y += G; m_right = 1; end
                     end
                  end
               end
            end
         end
      end
   endtask

   // Single compare process: advance the model by the edge just taken, then compare.
   always @(negedge clk_25MHz) begin
      if (s_valid) begin
         model_step();
         chk("aliens_x", int'(aliens_x), m_x);
         chk("aliens_y", int'(aliens_y), m_y);
         chk("index_aliens", int'(index_aliens), int'(m_mask));
         chk("hit", int'(hit), int'(m_hit));
         chk("game_over", int'(game_over), int'(m_go));
         chk("all_clear", int'(all_clear), int'(m_mask == 6'd0));
      end
   end

   // ---------------- directed + random stimulus ----------------
   int exp_x [12] = '{184, 224, 264, 304, 344, 344, 304, 264, 224, 184, 144, 144};
   int exp_y [12] = '{134, 134, 134, 134, 134, 174, 174, 174, 174, 174, 174, 214};

   task automatic cyc();
      @(negedge clk_25MHz);
   endtask

   task automatic reset_dut();
      d_reset = 1'b1; cyc(); d_reset = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_x"}, int'(aliens_x), 144);
      chk({tag, "_y"}, int'(aliens_y), 134);
      chk({tag, "_mask"}, int'(index_aliens), 63);
      chk({tag, "_hit"}, int'(hit), 0);
      chk({tag, "_go"}, int'(game_over), 0);
      chk({tag, "_clear"}, int'(all_clear), 0);
   endtask

   task automatic shoot(input int x, input int y);
      projectile_x = 10'(x); projectile_y = 10'(y); projectile_active = 1'b1;
      cyc();
      projectile_active = 1'b0;
   endtask

   task automatic do_step();
      frame_tick = 1'b1;
      repeat (MP) cyc();
      frame_tick = 1'b0;
   endtask

   task automatic march_until(input int y_target, input int bound);
      int n = 0;
      frame_tick = 1'b1;
      while (int'(aliens_y) != y_target && n < bound) begin
         cyc();
         n++;
      end
      frame_tick = 1'b0;
      chk("reach_y", int'(aliens_y), y_target);
   endtask

   initial begin
      int fx;
      d_reset = 1'b1; frame_tick = 1'b0; projectile_active = 1'b0;
      projectile_x = '0; projectile_y = '0;
      cyc(); cyc();
      check_reset("rst");
      d_reset = 1'b0;

      // Hits at reset position, repeat-hit suppression, gap miss.
      shoot(150, 140);
      chk("hit0", int'(hit), 1);
      chk("hit0_mask", int'(index_aliens), 6'b111110);
      projectile_active = 1'b1; cyc(); projectile_active = 1'b0;
      chk("rehit", int'(hit), 0);
      chk("rehit_mask", int'(index_aliens), 6'b111110);
      shoot(190, 140);
      chk("gap_hit", int'(hit), 0);
      chk("gap_mask", int'(index_aliens), 6'b111110);
      shoot(230, 220);
      chk("hit4", int'(hit), 1);
      chk("hit4_mask", int'(index_aliens), 6'b101110);
      cyc();

      // Twelve march steps: right sweep, drop, left sweep, drop.
      for (int k = 0; k < 12; k++) begin
         do_step();
         chk($sformatf("step%0d_x", k + 1), int'(aliens_x), exp_x[k]);
         chk($sformatf("step%0d_y", k + 1), int'(aliens_y), exp_y[k]);
      end

      // Win line with the lower row alive: bottom = y + 120.
      march_until(334, 400);
      chk("go_at_334", int'(game_over), 0);
      cyc();
      chk("go_next", int'(game_over), 1);
      fx = int'(aliens_x);
      projectile_x = 10'(fx + 86); projectile_y = 10'(340); projectile_active = 1'b1;
      frame_tick = 1'b1;
      repeat (4 * MP) cyc();
      frame_tick = 1'b0; projectile_active = 1'b0;
      chk("over_x", int'(aliens_x), fx);
      chk("over_y", int'(aliens_y), 334);
      chk("over_mask", int'(index_aliens), 6'b101110);
      chk("over_go", int'(game_over), 1);
      reset_dut();
      check_reset("rst_over");

      // Lower row cleared first: game ends only at y = 414.
      shoot(150, 220);
      shoot(230, 220);
      shoot(310, 220);
      chk("top_only_mask", int'(index_aliens), 6'b000111);
      march_until(334, 400);
      cyc(); cyc();
      chk("top_only_go334", int'(game_over), 0);
      march_until(414, 400);
      chk("top_only_go414", int'(game_over), 0);
      cyc();
      chk("top_only_go_next", int'(game_over), 1);

      // Last alien cleared on the same edge as a step.
      reset_dut();
      shoot(150, 140); shoot(230, 140); shoot(310, 140); shoot(150, 220); shoot(230, 220);
      chk("last_mask", int'(index_aliens), 6'b100000);
      frame_tick = 1'b1;
      repeat (MP - 1) cyc();
      projectile_x = 10'(310); projectile_y = 10'(220); projectile_active = 1'b1;
      cyc();
      projectile_active = 1'b0;
      chk("last_hit", int'(hit), 1);
      chk("last_clear", int'(all_clear), 1);
      chk("last_x", int'(aliens_x), 184);
      repeat (4 * MP) cyc();
      frame_tick = 1'b0;
      chk("clear_x", int'(aliens_x), 184);
      chk("clear_y", int'(aliens_y), 134);
      chk("clear_go", int'(game_over), 0);

      // Reset mid-march.
      reset_dut();
      frame_tick = 1'b1;
      repeat (3 * MP) cyc();
      chk("mid_x", int'(aliens_x), 264);
      d_reset = 1'b1; cyc(); d_reset = 1'b0; frame_tick = 1'b0;
      check_reset("rst_mid");

      // Randomized play.
      repeat (5000) begin
         d_reset           = ($urandom_range(0, 249) == 0);
         frame_tick        = ($urandom_range(0, 2) == 0);
         projectile_active = ($urandom_range(0, 11) == 0);
         projectile_x      = 10'($urandom_range(120, 620));
         projectile_y      = 10'($urandom_range(110, 480));
         cyc();
      end
      d_reset = 1'b0; frame_tick = 1'b0; projectile_active = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks,
               failures);
      $fatal(1, "watchdog expired");
   end

endmodule
